// File: rtl/rr_requester_if.sv
// Request/grant bundle between job sources, the requester front end and the arbiter.
// The master modport is the requester side; the slave modport is the arbiter/source side.
interface rr_requester_if #(
  parameter int REQUIRE_NUM = 4
);
  logic [REQUIRE_NUM-1:0] job_valid_i;
  logic [REQUIRE_NUM-1:0] job_drop_o;
  logic [REQUIRE_NUM-1:0] request_o;
  logic [REQUIRE_NUM-1:0] respond_i;
  logic [REQUIRE_NUM-1:0] active_ch_o;
  logic                   done_o;
  logic [REQUIRE_NUM-1:0] done_ch_o;
  logic                   grant_err_o;
  logic [REQUIRE_NUM-1:0] starve_o;

  modport master (
    input  job_valid_i, respond_i,
    output job_drop_o, request_o, active_ch_o, done_o, done_ch_o,
           grant_err_o, starve_o
  );

  modport slave (
    output job_valid_i, respond_i,
    input  job_drop_o, request_o, active_ch_o, done_o, done_ch_o,
           grant_err_o, starve_o
  );
endinterface

// File: rtl/rr_requester.sv
// Requester-side front end for the round-robin arbiter: per-channel job queueing,
// fixed-length service windows with a one-cycle release, and grant/starvation checking.
module rr_requester #(
  parameter int REQUIRE_NUM    = 4,
  parameter int CNT_WIDTH      = 4,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              sys_clk_i,
  input  logic              rst_n_i,
  rr_requester_if.master    bus
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVE,
    RELEASE
  } state_t;

  state_t                 state    [REQUIRE_NUM];
  logic [CNT_WIDTH-1:0]   pend     [REQUIRE_NUM];
  logic [CNT_WIDTH-1:0]   pend_nxt [REQUIRE_NUM];
  logic [HOLD_W-1:0]      hold     [REQUIRE_NUM];
  logic [WAIT_W-1:0]      wait_cnt [REQUIRE_NUM];

  logic [REQUIRE_NUM-1:0] drop_nxt;
  logic [REQUIRE_NUM-1:0] drop_q;
  logic [REQUIRE_NUM-1:0] starve_q;
  logic                   grant_err_q;
  logic                   multi_hot;
  logic                   stray;
  logic [REQUIRE_NUM-1:0] req_v;
  logic [REQUIRE_NUM-1:0] serve_v;
  logic [REQUIRE_NUM-1:0] rel_v;

  // Grant legality: a multi-hot grant blocks every channel; a bit aimed at an idle
  // channel is flagged. Bits seen in RELEASE are the registered arbiter echo and ignored.
  always_comb begin
    multi_hot = (bus.respond_i & (bus.respond_i - REQUIRE_NUM'(1))) != '0;
    stray     = 1'b0;
    for (int unsigned i = 0; i < REQUIRE_NUM; i++) begin
      if (bus.respond_i[i] && state[i] == IDLE) stray = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < REQUIRE_NUM; i++) begin
      pend_nxt[i] = pend[i];
      drop_nxt[i] = 1'b0;
      if (bus.job_valid_i[i] && state[i] != RELEASE) begin
        if (&pend[i]) drop_nxt[i] = 1'b1;
        else          pend_nxt[i] = pend[i] + CNT_WIDTH'(1);
      end else if (!bus.job_valid_i[i] && state[i] == RELEASE) begin
        pend_nxt[i] = pend[i] - CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < REQUIRE_NUM; i++) begin
      req_v[i]   = (state[i] == REQ);
      serve_v[i] = (state[i] == SERVE);
      rel_v[i]   = (state[i] == RELEASE);
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < REQUIRE_NUM; i++) begin
        state[i]    <= IDLE;
        pend[i]     <= '0;
        hold[i]     <= '0;
        wait_cnt[i] <= '0;
      end
      drop_q      <= '0;
      starve_q    <= '0;
      grant_err_q <= 1'b0;
    end else begin
      grant_err_q <= multi_hot | stray;
      drop_q      <= drop_nxt;
      for (int unsigned i = 0; i < REQUIRE_NUM; i++) begin
        pend[i] <= pend_nxt[i];

        if (state[i] == REQ) begin
          if (wait_cnt[i] != WAIT_W'(TIMEOUT_CYCLES)) wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
          if (wait_cnt[i] >= WAIT_W'(TIMEOUT_CYCLES - 1)) starve_q[i] <= 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end

        case (state[i])
          IDLE: begin
            if (pend[i] != '0) state[i] <= REQ;
          end
          REQ: begin
            if (bus.respond_i[i] && !multi_hot) begin
              state[i] <= SERVE;
              hold[i]  <= HOLD_W'(HOLD_CYCLES);
            end
          end
          SERVE: begin
            if (hold[i] == HOLD_W'(1)) state[i] <= RELEASE;
            else                       hold[i]  <= hold[i] - HOLD_W'(1);
          end
          RELEASE: begin
            state[i] <= (pend_nxt[i] != '0) ? REQ : IDLE;
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  assign bus.request_o   = req_v | serve_v;
  assign bus.active_ch_o = serve_v;
  assign bus.done_ch_o   = rel_v;
  assign bus.done_o      = |rel_v;
  assign bus.job_drop_o  = drop_q;
  assign bus.grant_err_o = grant_err_q;
  assign bus.starve_o    = starve_q;

endmodule

// File: tb/tb_rr_requester.sv
// Directed bench for rr_requester: latency, back-to-back windows, saturation,
// grant errors, starvation and reset abort, all with hand-computed expectations.
module tb_rr_requester;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_requester_if #(.REQUIRE_NUM(4)) bus ();

  rr_requester #(
    .REQUIRE_NUM    (4),
    .CNT_WIDTH      (4),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .sys_clk_i (clk),
    .rst_n_i   (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n           = 1'b0;
    bus.job_valid_i = '0;
    bus.respond_i   = '0;
    step;
    step;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n           = 1'b0;
    bus.job_valid_i = '0;
    bus.respond_i   = '0;
    step;
    step;
    checks++;
    if ({bus.request_o, bus.active_ch_o, bus.done_ch_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_req_act_done got %h exp 000", {bus.request_o, bus.active_ch_o, bus.done_ch_o});
    end
    checks++;
    if ({bus.done_o, bus.grant_err_o, bus.job_drop_o, bus.starve_o} !== 10'h000) begin
      errors++;
      $display("FAIL reset_flags got %h exp 000", {bus.done_o, bus.grant_err_o, bus.job_drop_o, bus.starve_o});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset;
    bus.job_valid_i = 4'b0001;            // cycle 0
    step;
    bus.job_valid_i = '0;                 // cycle 1
    checks++;
    if (bus.request_o !== 4'b0000) begin
      errors++; $display("FAIL single_req_c1 got %b exp 0000", bus.request_o);
    end
    step;                                 // cycle 2
    checks++;
    if (bus.request_o !== 4'b0001) begin
      errors++; $display("FAIL single_req_c2 got %b exp 0001", bus.request_o);
    end
    step; step; step;                     // cycle 5
    bus.respond_i = 4'b0001;
    checks++;
    if (bus.active_ch_o !== 4'b0000) begin
      errors++; $display("FAIL single_act_c5 got %b exp 0000", bus.active_ch_o);
    end
    step;                                 // cycle 6; grant dropped during SERVE
    bus.respond_i = '0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.active_ch_o !== 4'b0001 || bus.request_o !== 4'b0001 || bus.done_o !== 1'b0) begin
        errors++;
        $display("FAIL single_serve_c%0d got act=%b req=%b done=%b exp act=0001 req=0001 done=0",
                 6 + k, bus.active_ch_o, bus.request_o, bus.done_o);
      end
      step;
    end
    // cycle 10: RELEASE
    checks++;
    if (bus.request_o !== 4'b0000 || bus.done_o !== 1'b1 || bus.done_ch_o !== 4'b0001 ||
        bus.active_ch_o !== 4'b0000 || bus.grant_err_o !== 1'b0) begin
      errors++;
      $display("FAIL single_release got req=%b done=%b ch=%b act=%b err=%b exp 0000 1 0001 0000 0",
               bus.request_o, bus.done_o, bus.done_ch_o, bus.active_ch_o, bus.grant_err_o);
    end
    step;                                 // cycle 11: IDLE
    checks++;
    if (bus.request_o !== 4'b0000 || bus.done_o !== 1'b0 || bus.done_ch_o !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle got req=%b done=%b ch=%b exp 0000 0 0000",
               bus.request_o, bus.done_o, bus.done_ch_o);
    end
    step; step;
    checks++;
    if (bus.request_o !== 4'b0000) begin
      errors++; $display("FAIL single_stays_idle got %b exp 0000", bus.request_o);
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    for (int j = 0; j < 3; j++) begin
      bus.job_valid_i = 4'b0100;
      step;
    end
    bus.job_valid_i = '0;
    for (int n = 0; n < 10 && bus.request_o[2] !== 1'b1; n++) step;
    checks++;
    if (bus.request_o[2] !== 1'b1) begin
      errors++; $display("FAIL b2b_req_timeout got %b exp 1", bus.request_o[2]);
    end
    for (int w = 0; w < 3; w++) begin
      step;
      bus.respond_i = 4'b0100;
      step;
      bus.respond_i = '0;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (bus.active_ch_o !== 4'b0100 || bus.request_o[2] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_serve_w%0d_k%0d got act=%b req=%b exp act=0100 req=1",
                   w, k, bus.active_ch_o, bus.request_o[2]);
        end
        step;
      end
      checks++;
      if (bus.request_o[2] !== 1'b0 || bus.done_o !== 1'b1 || bus.done_ch_o !== 4'b0100) begin
        errors++;
        $display("FAIL b2b_release_w%0d got req=%b done=%b ch=%b exp 0 1 0100",
                 w, bus.request_o[2], bus.done_o, bus.done_ch_o);
      end
      step;
      checks++;
      if (bus.request_o[2] !== ((w < 2) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL b2b_after_w%0d got %b exp %b", w, bus.request_o[2], (w < 2) ? 1'b1 : 1'b0);
      end
    end
    step; step; step;
    checks++;
    if (bus.request_o !== 4'b0000) begin
      errors++; $display("FAIL b2b_pending_empty got %b exp 0000", bus.request_o);
    end
  endtask

  task automatic test_saturation;
    int dones;
    int gerrs;
    logic [3:0] exp_drop;
    do_reset;
    for (int c = 0; c < 19; c++) begin
      bus.job_valid_i = (c < 17) ? 4'b0010 : 4'b0000;
      exp_drop = (c == 16 || c == 17) ? 4'b0010 : 4'b0000;
      checks++;
      if (bus.job_drop_o !== exp_drop) begin
        errors++; $display("FAIL sat_drop_c%0d got %b exp %b", c, bus.job_drop_o, exp_drop);
      end
      step;
    end
    bus.job_valid_i = '0;
    dones = 0;
    gerrs = 0;
    for (int n = 0; n < 130; n++) begin
      bus.respond_i = bus.request_o & 4'b0010;
      if (bus.done_o === 1'b1) dones++;
      if (bus.grant_err_o !== 1'b0) gerrs++;
      step;
    end
    bus.respond_i = '0;
    checks++;
    if (dones !== 15) begin
      errors++; $display("FAIL sat_done_count got %0d exp 15", dones);
    end
    checks++;
    if (gerrs !== 0 || bus.request_o !== 4'b0000) begin
      errors++; $display("FAIL sat_drain got errs=%0d req=%b exp 0 0000", gerrs, bus.request_o);
    end
  endtask

  task automatic test_grant_err;
    do_reset;
    bus.job_valid_i = 4'b1000;
    step;
    bus.job_valid_i = '0;
    step;
    checks++;
    if (bus.request_o !== 4'b1000) begin
      errors++; $display("FAIL gerr_req3 got %b exp 1000", bus.request_o);
    end
    bus.respond_i = 4'b1010;
    step;
    bus.respond_i = '0;
    checks++;
    if (bus.grant_err_o !== 1'b1 || bus.active_ch_o !== 4'b0000) begin
      errors++;
      $display("FAIL gerr_multihot got err=%b act=%b exp 1 0000", bus.grant_err_o, bus.active_ch_o);
    end
    step;
    checks++;
    if (bus.grant_err_o !== 1'b0 || bus.active_ch_o !== 4'b0000 || bus.request_o !== 4'b1000) begin
      errors++;
      $display("FAIL gerr_multihot_after got err=%b act=%b req=%b exp 0 0000 1000",
               bus.grant_err_o, bus.active_ch_o, bus.request_o);
    end
    bus.respond_i = 4'b0001;
    step;
    bus.respond_i = '0;
    checks++;
    if (bus.grant_err_o !== 1'b1 || bus.request_o !== 4'b1000 || bus.active_ch_o !== 4'b0000) begin
      errors++;
      $display("FAIL gerr_idle_grant got err=%b req=%b act=%b exp 1 1000 0000",
               bus.grant_err_o, bus.request_o, bus.active_ch_o);
    end
    step;
    checks++;
    if (bus.grant_err_o !== 1'b0) begin
      errors++; $display("FAIL gerr_idle_after got %b exp 0", bus.grant_err_o);
    end
    // Legal grant held through SERVE and RELEASE: no error expected.
    bus.respond_i = 4'b1000;
    for (int k = 0; k < 5; k++) step;
    checks++;
    if (bus.done_ch_o !== 4'b1000 || bus.grant_err_o !== 1'b0) begin
      errors++;
      $display("FAIL gerr_hold_release got ch=%b err=%b exp 1000 0", bus.done_ch_o, bus.grant_err_o);
    end
    step;
    bus.respond_i = '0;
    checks++;
    if (bus.grant_err_o !== 1'b0 || bus.request_o !== 4'b0000) begin
      errors++;
      $display("FAIL gerr_release_tolerated got err=%b req=%b exp 0 0000", bus.grant_err_o, bus.request_o);
    end
  endtask

  task automatic test_starve;
    logic [3:0] exp_st;
    do_reset;
    bus.job_valid_i = 4'b0001;
    step;
    bus.job_valid_i = '0;
    for (int c = 1; c <= 68; c++) begin
      exp_st = (c >= 66) ? 4'b0001 : 4'b0000;
      if (c == 64 || c == 65 || c == 66 || c == 68) begin
        checks++;
        if (bus.starve_o !== exp_st) begin
          errors++; $display("FAIL starve_c%0d got %b exp %b", c, bus.starve_o, exp_st);
        end
      end
      step;
    end
    bus.respond_i = 4'b0001;
    step;
    bus.respond_i = '0;
    for (int k = 0; k < 7; k++) step;
    checks++;
    if (bus.starve_o !== 4'b0001 || bus.request_o !== 4'b0000) begin
      errors++;
      $display("FAIL starve_sticky got st=%b req=%b exp 0001 0000", bus.starve_o, bus.request_o);
    end
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    checks++;
    if (bus.starve_o !== 4'b0000) begin
      errors++; $display("FAIL starve_reset got %b exp 0000", bus.starve_o);
    end
  endtask

  task automatic test_reset_mid_serve;
    do_reset;
    bus.job_valid_i = 4'b0010;
    step;
    bus.job_valid_i = '0;
    step;                                 // cycle 2: REQ
    bus.respond_i = 4'b0010;
    step;                                 // cycle 3: SERVE #1
    bus.respond_i = '0;
    step; step;                           // cycle 5: SERVE #3
    checks++;
    if (bus.active_ch_o !== 4'b0010) begin
      errors++; $display("FAIL abort_pre_serve got %b exp 0010", bus.active_ch_o);
    end
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    checks++;
    if ({bus.request_o, bus.active_ch_o, bus.done_ch_o, bus.done_o, bus.grant_err_o,
         bus.job_drop_o, bus.starve_o} !== 22'h0) begin
      errors++;
      $display("FAIL abort_outputs got req=%b act=%b ch=%b done=%b err=%b drop=%b st=%b exp all 0",
               bus.request_o, bus.active_ch_o, bus.done_ch_o, bus.done_o, bus.grant_err_o,
               bus.job_drop_o, bus.starve_o);
    end
    for (int k = 0; k < 6; k++) begin
      step;
      checks++;
      if (bus.done_o !== 1'b0 || bus.request_o !== 4'b0000) begin
        errors++;
        $display("FAIL abort_after_k%0d got done=%b req=%b exp 0 0000", k, bus.done_o, bus.request_o);
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.job_valid_i = '0;
    bus.respond_i   = '0;
    test_reset;
    test_single;
    test_back_to_back;
    test_saturation;
    test_grant_err;
    test_starve;
    test_reset_mid_serve;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
